// File: rtl/car_rearlight_gen_if.sv
// car_rearlight_gen_if
//   Command and LED bundle between the switch/key input block and the
//   rear-light controller.
//
//   Signals:
//     state_in   [3:0]         active-low one-cold driver command
//     hazard                   level, forces both clusters to blink
//     seq_en                   level, sequential-fill flow for LEFT/RIGHT
//     led_left   [SIDE_W-1:0]  left cluster, active-low
//     led_right  [SIDE_W-1:0]  right cluster, active-low
//     led_flow   [FLOW_W-1:0]  centre flow bar, active-low
//     state_out  [2:0]         accepted state code
//
//   Modports:
//     master  command source / LED consumer
//     slave   the controller
interface car_rearlight_gen_if #(
  parameter int SIDE_W = 3,
  parameter int FLOW_W = 8
);
  logic [3:0]        state_in;
  logic              hazard;
  logic              seq_en;
  logic [SIDE_W-1:0] led_left;
  logic [SIDE_W-1:0] led_right;
  logic [FLOW_W-1:0] led_flow;
  logic [2:0]        state_out;

  modport master (
    output state_in, hazard, seq_en,
    input  led_left, led_right, led_flow, state_out
  );

  modport slave (
    input  state_in, hazard, seq_en,
    output led_left, led_right, led_flow, state_out
  );
endinterface

// File: rtl/car_rearlight_gen.sv
// car_rearlight_gen
//   Rear-light controller. Filters a 4-bit one-cold driver command, keeps
//   the accepted state, and drives two indicator clusters plus a centre
//   flow bar (all active-low) with blink, rotate and sequential-fill
//   patterns. A hazard level overrides the clusters only.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   car_rearlight_gen_if.slave (state_in, hazard, seq_en in;
//           led_left, led_right, led_flow, state_out out)
//
//   Pipeline:
//     p0  input sample register and stability counter
//     p1  accepted state, blink/flow timers, flow pattern registers
//     p2  registered LED outputs
module car_rearlight_gen #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 1,
  parameter int FLOW_HZ    = 8,
  parameter int SIDE_W     = 3,
  parameter int FLOW_W     = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  car_rearlight_gen_if.slave  bus
);

  localparam int HALF_P   = CLK_HZ / (2 * BLINK_HZ);
  localparam int STEP_P   = CLK_HZ / FLOW_HZ;
  localparam int BLINK_CW = (HALF_P > 1) ? $clog2(HALF_P) : 1;
  localparam int FLOW_CW  = (STEP_P > 1) ? $clog2(STEP_P) : 1;
  localparam int STAB_CW  = $clog2(STABLE_CYC + 1);
  localparam int HALF_W   = FLOW_W / 2;
  localparam int FILL_CW  = $clog2(HALF_W + 1);

  localparam logic [FLOW_W-1:0] UPPER_M = {{HALF_W{1'b1}}, {HALF_W{1'b0}}};
  localparam logic [FLOW_W-1:0] LOWER_M = {{HALF_W{1'b0}}, {HALF_W{1'b1}}};

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_GO    = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_BACK  = 3'd4
  } state_t;

  // Unlisted command codes fall back to STOP.
  function automatic state_t decode_cmd(input logic [3:0] c);
    case (c)
      4'b1110: return ST_GO;
      4'b1101: return ST_LEFT;
      4'b1011: return ST_RIGHT;
      4'b0111: return ST_BACK;
      default: return ST_STOP;
    endcase
  endfunction

  // Lit mask (1 = lit) loaded when a state is entered. Only GO and BACK
  // consume it; the fill modes use fill_p1 instead.
  function automatic logic [FLOW_W-1:0] start_lit(input state_t s);
    case (s)
      ST_GO:   return {1'b1, {(FLOW_W-1){1'b0}}};
      ST_BACK: return {{(FLOW_W-1){1'b0}}, 1'b1};
      default: return '0;
    endcase
  endfunction

  function automatic logic [FLOW_W-1:0] step_lit(input state_t s,
                                                 input logic [FLOW_W-1:0] x);
    case (s)
      ST_GO:   return {x[0], x[FLOW_W-1:1]};
      ST_BACK: return {x[FLOW_W-2:0], x[FLOW_W-1]};
      default: return x;
    endcase
  endfunction

  // n lit bits growing outward from the centre of the chosen half.
  function automatic logic [FLOW_W-1:0] fill_mask(input logic left,
                                                  input logic [FILL_CW-1:0] n);
    logic [FLOW_W-1:0] m;
    m = '0;
    for (int i = 0; i < HALF_W; i++) begin
      if (i < int'(n)) begin
        if (left) m[HALF_W + i]     = 1'b1;
        else      m[HALF_W - 1 - i] = 1'b1;
      end
    end
    return m;
  endfunction

  // ---- p0: input sample and stability filter ----
  logic [3:0]         samp_p0;
  logic [STAB_CW-1:0] stab_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_p0 <= 4'b1111;
      stab_p0 <= '0;
    end else begin
      samp_p0 <= bus.state_in;
      if (bus.state_in != samp_p0)
        stab_p0 <= STAB_CW'(1);
      else if (stab_p0 != STAB_CW'(STABLE_CYC))
        stab_p0 <= stab_p0 + STAB_CW'(1);
    end
  end

  // ---- p1: accepted state, timers, flow pattern ----
  state_t              state_p1;
  logic [BLINK_CW-1:0] blink_cnt_p1;
  logic                phase_p1;
  logic [FLOW_CW-1:0]  flow_cnt_p1;
  logic [FLOW_W-1:0]   lit_p1;
  logic [FILL_CW-1:0]  fill_p1;
  logic                seq_p1;

  state_t cmd_state;
  logic   accept;
  logic   blink_tc;
  logic   flow_tick;

  assign cmd_state = decode_cmd(samp_p0);
  assign accept    = (stab_p0 == STAB_CW'(STABLE_CYC)) && (cmd_state != state_p1);
  assign blink_tc  = (blink_cnt_p1 == BLINK_CW'(HALF_P - 1));
  assign flow_tick = (flow_cnt_p1 == FLOW_CW'(STEP_P - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1     <= ST_STOP;
      blink_cnt_p1 <= '0;
      phase_p1     <= 1'b0;
      flow_cnt_p1  <= '0;
      lit_p1       <= '0;
      fill_p1      <= '0;
      seq_p1       <= 1'b0;
    end else begin
      seq_p1 <= bus.seq_en;
      if (accept) begin
        // A state change restarts every pattern; a coincident flow tick
        // is swallowed by the reload.
        state_p1     <= cmd_state;
        blink_cnt_p1 <= '0;
        phase_p1     <= 1'b1;
        flow_cnt_p1  <= '0;
        lit_p1       <= start_lit(cmd_state);
        fill_p1      <= '0;
      end else begin
        if (blink_tc) begin
          blink_cnt_p1 <= '0;
          phase_p1     <= ~phase_p1;
        end else begin
          blink_cnt_p1 <= blink_cnt_p1 + BLINK_CW'(1);
        end

        if (flow_tick) begin
          flow_cnt_p1 <= '0;
          lit_p1      <= step_lit(state_p1, lit_p1);
        end else begin
          flow_cnt_p1 <= flow_cnt_p1 + FLOW_CW'(1);
        end

        // Fill has HALF_W+1 stages including empty; a seq_en edge
        // restarts it from empty.
        if (bus.seq_en != seq_p1)
          fill_p1 <= '0;
        else if (flow_tick)
          fill_p1 <= (fill_p1 == FILL_CW'(HALF_W)) ? '0 : fill_p1 + FILL_CW'(1);
      end
    end
  end

  // ---- p2: registered LED outputs ----
  logic [SIDE_W-1:0] blink_v;
  logic [SIDE_W-1:0] left_d;
  logic [SIDE_W-1:0] right_d;
  logic [FLOW_W-1:0] flow_lit_d;

  always_comb begin
    blink_v    = phase_p1 ? {SIDE_W{1'b0}} : {SIDE_W{1'b1}};
    left_d     = {SIDE_W{1'b1}};
    right_d    = {SIDE_W{1'b1}};
    flow_lit_d = {FLOW_W{1'b1}};
    case (state_p1)
      ST_GO: begin
        left_d     = {SIDE_W{1'b0}};
        right_d    = {SIDE_W{1'b0}};
        flow_lit_d = lit_p1;
      end
      ST_BACK: begin
        flow_lit_d = lit_p1;
      end
      ST_LEFT: begin
        left_d     = blink_v;
        flow_lit_d = seq_p1 ? fill_mask(1'b1, fill_p1) : UPPER_M;
      end
      ST_RIGHT: begin
        right_d    = blink_v;
        flow_lit_d = seq_p1 ? fill_mask(1'b0, fill_p1) : LOWER_M;
      end
      default: begin
        left_d  = blink_v;
        right_d = blink_v;
      end
    endcase
    // Hazard is deliberately unfiltered and touches the clusters only.
    if (bus.hazard) begin
      left_d  = blink_v;
      right_d = blink_v;
    end
  end

  logic [SIDE_W-1:0] led_left_p2;
  logic [SIDE_W-1:0] led_right_p2;
  logic [FLOW_W-1:0] led_flow_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_left_p2  <= {SIDE_W{1'b1}};
      led_right_p2 <= {SIDE_W{1'b1}};
      led_flow_p2  <= {FLOW_W{1'b0}};
    end else begin
      led_left_p2  <= left_d;
      led_right_p2 <= right_d;
      led_flow_p2  <= ~flow_lit_d;
    end
  end

  assign bus.led_left  = led_left_p2;
  assign bus.led_right = led_right_p2;
  assign bus.led_flow  = led_flow_p2;
  assign bus.state_out = state_p1;

endmodule

// File: tb/tb_car_rearlight_gen.sv
// tb_car_rearlight_gen
//   Directed bench for car_rearlight_gen with a 16 Hz clock model:
//   blink half-period 8 cycles, flow step 4 cycles, 3-sample filter.
//   All actions happen 1 time unit after a rising edge; "eN" below is
//   the N-th edge after the most recent reset release.
module tb_car_rearlight_gen;
  localparam int SIDE_W = 3;
  localparam int FLOW_W = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  car_rearlight_gen_if #(.SIDE_W(SIDE_W), .FLOW_W(FLOW_W)) bus ();

  car_rearlight_gen #(
    .CLK_HZ(16), .BLINK_HZ(1), .FLOW_HZ(4),
    .SIDE_W(SIDE_W), .FLOW_W(FLOW_W), .STABLE_CYC(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.state_in = 4'b1111;
    bus.hazard   = 1'b0;
    bus.seq_en   = 1'b0;

    // Reset values
    step(3);
    chk("rst_flow",  32'(bus.led_flow),  32'b00000000);
    chk("rst_left",  32'(bus.led_left),  32'b111);
    chk("rst_right", 32'(bus.led_right), 32'b111);
    chk("rst_state", 32'(bus.state_out), 0);
    rst = 1'b0;                                    // e0

    // STOP: clusters 111 through e8, 000 from e9 to e16, 111 at e17
    step(4);                                       // e4
    chk("stop_left_e4", 32'(bus.led_left), 32'b111);
    chk("stop_flow_e4", 32'(bus.led_flow), 32'b00000000);
    step(5);                                       // e9
    chk("stop_left_e9",  32'(bus.led_left),  32'b000);
    chk("stop_right_e9", 32'(bus.led_right), 32'b000);
    step(8);                                       // e17
    chk("stop_left_e17", 32'(bus.led_left), 32'b111);

    // GO: sampled e18..e20, accepted e21, outputs e22, steps every 4
    bus.state_in = 4'b1110;
    step(3);                                       // e20
    chk("go_state_e20", 32'(bus.state_out), 0);
    step(1);                                       // e21
    chk("go_state_e21", 32'(bus.state_out), 1);
    step(1);                                       // e22
    chk("go_flow_e22", 32'(bus.led_flow), 32'b01111111);
    chk("go_left_e22", 32'(bus.led_left), 32'b000);
    chk("go_right_e22", 32'(bus.led_right), 32'b000);
    step(4);                                       // e26
    chk("go_flow_e26", 32'(bus.led_flow), 32'b10111111);
    step(24);                                      // e50, 7 steps
    chk("go_flow_e50", 32'(bus.led_flow), 32'b11111110);
    step(4);                                       // e54, 8 steps: wrap
    chk("go_flow_e54", 32'(bus.led_flow), 32'b01111111);

    // Two-cycle LEFT glitch must be ignored, no reload
    bus.state_in = 4'b1101;
    step(2);                                       // e56
    bus.state_in = 4'b1110;
    step(2);                                       // e58
    chk("glitch_state_e58", 32'(bus.state_out), 1);
    chk("glitch_flow_e58",  32'(bus.led_flow), 32'b10111111);
    step(4);                                       // e62
    chk("glitch_state_e62", 32'(bus.state_out), 1);
    chk("glitch_flow_e62",  32'(bus.led_flow), 32'b11011111);

    // RIGHT with sequential fill: accepted e66
    bus.state_in = 4'b1011;
    bus.seq_en   = 1'b1;
    step(4);                                       // e66
    chk("right_state", 32'(bus.state_out), 3);
    step(1);                                       // e67
    chk("right_flow_0",  32'(bus.led_flow),  32'b11111111);
    chk("right_rled_0",  32'(bus.led_right), 32'b000);
    chk("right_lled_0",  32'(bus.led_left),  32'b111);
    step(4);                                       // e71
    chk("right_flow_1", 32'(bus.led_flow), 32'b11110111);
    step(4);                                       // e75
    chk("right_flow_2", 32'(bus.led_flow), 32'b11110011);
    chk("right_rled_2", 32'(bus.led_right), 32'b111);
    step(4);                                       // e79
    chk("right_flow_3", 32'(bus.led_flow), 32'b11110001);
    step(4);                                       // e83
    chk("right_flow_4", 32'(bus.led_flow), 32'b11110000);
    chk("right_rled_4", 32'(bus.led_right), 32'b000);
    step(4);                                       // e87
    chk("right_flow_wrap", 32'(bus.led_flow), 32'b11111111);

    // BACK: accepted e91, outputs e92
    bus.state_in = 4'b0111;
    bus.seq_en   = 1'b0;
    step(4);                                       // e91
    chk("back_state", 32'(bus.state_out), 4);
    step(1);                                       // e92
    chk("back_flow_e92", 32'(bus.led_flow), 32'b11111110);
    chk("back_left_e92", 32'(bus.led_left), 32'b111);
    bus.hazard = 1'b1;
    step(1);                                       // e93
    chk("haz_left_e93",  32'(bus.led_left),  32'b000);
    chk("haz_right_e93", 32'(bus.led_right), 32'b000);
    chk("haz_flow_e93",  32'(bus.led_flow),  32'b11111110);
    step(3);                                       // e96
    chk("haz_flow_e96", 32'(bus.led_flow), 32'b11111101);
    step(4);                                       // e100
    chk("haz_left_e100", 32'(bus.led_left), 32'b111);
    chk("haz_flow_e100", 32'(bus.led_flow), 32'b11111011);
    step(8);                                       // e108
    chk("haz_left_e108",  32'(bus.led_left),  32'b000);
    chk("haz_right_e108", 32'(bus.led_right), 32'b000);
    bus.hazard = 1'b0;
    step(1);                                       // e109
    chk("unhaz_left",  32'(bus.led_left),  32'b111);
    chk("unhaz_right", 32'(bus.led_right), 32'b111);
    chk("unhaz_flow",  32'(bus.led_flow),  32'b11101111);

    // LEFT with fill: accepted e113, outputs e114
    bus.state_in = 4'b1101;
    bus.seq_en   = 1'b1;
    step(5);                                       // e114
    chk("left_flow_0", 32'(bus.led_flow), 32'b11111111);
    step(4);                                       // e118
    chk("left_flow_1", 32'(bus.led_flow),  32'b11101111);
    chk("left_lled_1", 32'(bus.led_left),  32'b000);
    chk("left_rled_1", 32'(bus.led_right), 32'b111);
    step(4);                                       // e122
    chk("left_flow_2", 32'(bus.led_flow), 32'b11001111);

    // Asynchronous reset mid-fill
    rst = 1'b1;
    #1;
    chk("arst_flow",  32'(bus.led_flow),  32'b00000000);
    chk("arst_left",  32'(bus.led_left),  32'b111);
    chk("arst_right", 32'(bus.led_right), 32'b111);
    chk("arst_state", 32'(bus.state_out), 0);
    step(2);
    rst = 1'b0;                                    // e0
    step(3);                                       // e3
    chk("reacc_state_e3", 32'(bus.state_out), 0);
    step(1);                                       // e4
    chk("reacc_state_e4", 32'(bus.state_out), 2);
    step(1);                                       // e5
    chk("reacc_flow_0", 32'(bus.led_flow), 32'b11111111);
    chk("reacc_lled_0", 32'(bus.led_left), 32'b000);
    step(4);                                       // e9
    chk("reacc_flow_1", 32'(bus.led_flow), 32'b11101111);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
